spi_slave: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 198 +++++++++++++++++++
 tb/tb_spi_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared state encoding and helpers for spi_slave
package spi_slave_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must be able to hold the value SIZE itself
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchroniser with edge detection
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Synchroniser chain plus one history flop, reset to the pin's idle level
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  =  r_sync[SYNC_STAGES-1] & ~r_hist;
    assign fall  = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder, optional frame-error output under SPI_SLAVE_FRAME_ERR_EN
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SIZE        = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            sclk_in,
    input  logic            cs_n_in,
    input  logic            mosi_in,
    output logic            miso_out,
    input  logic [SIZE-1:0] tx_data_in,
    input  logic            tx_load_in,
    output logic [SIZE-1:0] rx_data_out,
    output logic            r_rx_valid_out,
    output logic            busy_out
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic            r_frame_err_out
`endif
);

    localparam int            CW       = cnt_width(SIZE);
    localparam logic [CW-1:0] CNT_FULL = CW'(SIZE);

    // Synchronised pins and edges
    logic w_sclk_level_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_level_unused;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .async_in   (sclk_in),
        .level      (w_sclk_level_unused),
        .rise       (w_sclk_rise),
        .fall       (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .async_in   (cs_n_in),
        .level      (w_cs_level_unused),
        .rise       (w_cs_rise),
        .fall       (w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .async_in   (mosi_in),
        .level      (w_mosi),
        .rise       (w_mosi_rise_unused),
        .fall       (w_mosi_fall_unused)
    );

    // State and datapath registers
    state_t          r_state;
    logic [SIZE-1:0] r_tx_buf;
    logic [SIZE-1:0] r_tx_shift;
    logic [SIZE-1:0] r_rx_shift;
    logic [CW-1:0]   r_bit_cnt;
    logic [SIZE-1:0] r_rx_data;
    logic            r_miso;

    // Next-state values
    state_t          w_state_nxt;
    logic [SIZE-1:0] w_tx_buf_nxt;
    logic [SIZE-1:0] w_tx_shift_nxt;
    logic [SIZE-1:0] w_rx_shift_nxt;
    logic [CW-1:0]   w_bit_cnt_nxt;
    logic [SIZE-1:0] w_rx_data_nxt;
    logic            w_rx_valid_nxt;
    logic            w_miso_nxt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic            r_frame_err;
    logic            w_frame_err_nxt;
`endif

    // Register update; reset returns every output to zero immediately
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_state        <= ST_IDLE;
            r_tx_buf       <= '0;
            r_tx_shift     <= '0;
            r_rx_shift     <= '0;
            r_bit_cnt      <= '0;
            r_rx_data      <= '0;
            r_rx_valid_out <= 1'b0;
            r_miso         <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            r_frame_err    <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_tx_buf       <= w_tx_buf_nxt;
            r_tx_shift     <= w_tx_shift_nxt;
            r_rx_shift     <= w_rx_shift_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid_out <= w_rx_valid_nxt;
            r_miso         <= w_miso_nxt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            r_frame_err    <= w_frame_err_nxt;
`endif
        end
    end

    // Frame FSM: next state, shift registers, completion and error pulses
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_buf_nxt   = r_tx_buf;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_miso_nxt     = r_miso;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        w_frame_err_nxt = 1'b0;
`endif

        // The buffer only feeds the shift register at CS fall, so a load in
        // that same cycle lands after the old value has been captured.
        if (tx_load_in) begin
            w_tx_buf_nxt = tx_data_in;
        end

        case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_tx_shift_nxt = r_tx_buf;
                    w_miso_nxt     = r_tx_buf[SIZE-1];
                    w_rx_shift_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (r_bit_cnt == CNT_FULL) begin
                    // Full word was shifted in on the previous cycle
                    w_rx_data_nxt  = r_rx_shift;
                    w_rx_valid_nxt = 1'b1;
                    w_miso_nxt     = 1'b0;
                    w_state_nxt    = w_cs_rise ? ST_IDLE : ST_DONE;
                end else if (w_cs_rise) begin
                    w_miso_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    w_frame_err_nxt = 1'b1;
`endif
                end else if (w_sclk_rise) begin
                    w_rx_shift_nxt = {r_rx_shift[SIZE-2:0], w_mosi};
                    w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                end else if (w_sclk_fall) begin
                    w_tx_shift_nxt = {r_tx_shift[SIZE-2:0], 1'b0};
                    w_miso_nxt     = r_tx_shift[SIZE-2];
                end
            end

            ST_DONE: begin
                w_miso_nxt = 1'b0;
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef SPI_SLAVE_FRAME_ERR_EN
                else if (w_sclk_rise) begin
                    w_frame_err_nxt = 1'b1;
                end
`endif
            end

            default: begin
                w_miso_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign miso_out    = r_miso;
    assign rx_data_out = r_rx_data;
    assign busy_out    = (r_state != ST_IDLE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign r_frame_err_out = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed table-driven bench for spi_slave
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int SIZE = 40;
    localparam int SYNC = 2;

    logic            clk_in = 1'b0;
    logic            reset_n_in = 1'b0;
    logic            sclk_in = 1'b0;
    logic            cs_n_in = 1'b1;
    logic            mosi_in = 1'b0;
    logic            miso_out;
    logic [SIZE-1:0] tx_data_in = '0;
    logic            tx_load_in = 1'b0;
    logic [SIZE-1:0] rx_data_out;
    logic            r_rx_valid_out;
    logic            busy_out;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic            r_frame_err_out;
`endif

    spi_slave #(.SIZE(SIZE), .SYNC_STAGES(SYNC)) dut (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .sclk_in        (sclk_in),
        .cs_n_in        (cs_n_in),
        .mosi_in        (mosi_in),
        .miso_out       (miso_out),
        .tx_data_in     (tx_data_in),
        .tx_load_in     (tx_load_in),
        .rx_data_out    (rx_data_out),
        .r_rx_valid_out (r_rx_valid_out),
        .busy_out       (busy_out)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .r_frame_err_out(r_frame_err_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int err_cnt  = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (r_rx_valid_out === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (r_frame_err_out === 1'b1) err_cnt = err_cnt + 1;
`endif
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic load_buf(input logic [SIZE-1:0] val);
        tx_data_in = val;
        tx_load_in = 1'b1;
        tick(1);
        tx_load_in = 1'b0;
        tick(1);
    endtask

    // One SPI frame from the master side: SCLK = clk/8, MISO sampled just before each rise
    task automatic spi_frame(input logic [SIZE-1:0] mosi_w, input int nbits,
                             input bit collide, input logic [SIZE-1:0] collide_val,
                             input int rst_bit,
                             output logic [63:0] miso_w, output int rise40_cyc);
        miso_w = '0;
        rise40_cyc = 0;
        cs_n_in = 1'b0;
        if (collide) begin
            // Load lands in the cycle the synchronised CS fall is acted on
            tick(2);
            tx_data_in = collide_val;
            tx_load_in = 1'b1;
            tick(1);
            tx_load_in = 1'b0;
            tick(5);
        end else begin
            tick(8);
        end
        for (int i = 0; i < nbits; i++) begin
            mosi_in = (i < SIZE) ? mosi_w[SIZE-1-i] : 1'b0;
            if (i == rst_bit) begin
                reset_n_in = 1'b0;
                tick(1);
                reset_n_in = 1'b1;
                @(negedge clk_in);
                check("rst_mid_miso",  {63'd0, miso_out}, 64'd0);
                check("rst_mid_rx",    {24'd0, rx_data_out}, 64'd0);
                check("rst_mid_valid", {63'd0, r_rx_valid_out}, 64'd0);
                check("rst_mid_busy",  {63'd0, busy_out}, 64'd0);
                tick(3);
            end else begin
                tick(4);
            end
            miso_w = {miso_w[62:0], miso_out};
            sclk_in = 1'b1;
            if (i == SIZE-1) rise40_cyc = cyc;
            tick(4);
            sclk_in = 1'b0;
        end
        tick(8);
        cs_n_in = 1'b1;
        tick(4);
        check("busy_after_cs", {63'd0, busy_out}, 64'd0);
        tick(4);
    endtask

    typedef struct {
        bit              do_load;
        logic [SIZE-1:0] load_val;
        logic [SIZE-1:0] mosi;
        int              nbits;
        logic [63:0]     exp_miso;
        logic [SIZE-1:0] exp_rx;
        int              exp_valid;
        int              exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [63:0] miso_w;
        int          r40;
        int          v0, e0;

        // Normal frame, reload-free repeat, abort at 17 bits, over-length 41 bits
        vecs[0] = '{1'b1, 40'hA5_5A_0F_F0_C3, 40'h12_34_56_78_9A, 40,
                    64'h00_0000_00A5_5A0F_F0C3, 40'h12_34_56_78_9A, 1, 0};
        vecs[1] = '{1'b0, 40'h0, 40'hFE_DC_BA_98_76, 40,
                    64'h00_0000_00A5_5A0F_F0C3, 40'hFE_DC_BA_98_76, 1, 0};
        vecs[2] = '{1'b0, 40'h0, 40'h0F_0F_0F_0F_0F, 17,
                    64'h0000_0000_0001_4AB4, 40'hFE_DC_BA_98_76, 0, 1};
        vecs[3] = '{1'b1, 40'h00_00_00_00_01, 40'hAA_AA_AA_AA_AA, 41,
                    64'h0000_0000_0000_0002, 40'hAA_AA_AA_AA_AA, 1, 1};

        tick(4);
        reset_n_in = 1'b1;
        tick(1);
        @(negedge clk_in);
        check("reset_miso",  {63'd0, miso_out}, 64'd0);
        check("reset_rx",    {24'd0, rx_data_out}, 64'd0);
        check("reset_valid", {63'd0, r_rx_valid_out}, 64'd0);
        check("reset_busy",  {63'd0, busy_out}, 64'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("reset_err",   {63'd0, r_frame_err_out}, 64'd0);
`endif
        tick(2);

        for (int k = 0; k < 4; k++) begin
            if (vecs[k].do_load) load_buf(vecs[k].load_val);
            v0 = valid_cnt;
            e0 = err_cnt;
            spi_frame(vecs[k].mosi, vecs[k].nbits, 1'b0, '0, -1, miso_w, r40);
            check($sformatf("v%0d_miso", k), miso_w, vecs[k].exp_miso);
            check($sformatf("v%0d_rx", k), {24'd0, rx_data_out}, {24'd0, vecs[k].exp_rx});
            check($sformatf("v%0d_valid", k), 64'(valid_cnt - v0), 64'(vecs[k].exp_valid));
            if (vecs[k].nbits >= SIZE)
                check($sformatf("v%0d_latency", k), 64'(valid_cyc - r40), 64'(SYNC + 2));
`ifdef SPI_SLAVE_FRAME_ERR_EN
            check($sformatf("v%0d_err", k), 64'(err_cnt - e0), 64'(vecs[k].exp_err));
`endif
        end

        // Load coincident with CS fall: old buffer this frame, new one next
        spi_frame(40'h11_11_11_11_11, 40, 1'b1, 40'hFF_FF_FF_FF_FF, -1, miso_w, r40);
        check("collide_miso_old", miso_w, 64'h0000_0000_0000_0001);
        check("collide_rx", {24'd0, rx_data_out}, 64'h11_11_11_11_11);
        spi_frame(40'h22_22_22_22_22, 40, 1'b0, '0, -1, miso_w, r40);
        check("collide_miso_new", miso_w, 64'h00_0000_00FF_FFFF_FFFF);
        check("collide_rx2", {24'd0, rx_data_out}, 64'h22_22_22_22_22);

        // Reset pulse at bit 20, then a clean frame with the cleared buffer
        v0 = valid_cnt;
        e0 = err_cnt;
        spi_frame(40'h33_33_33_33_33, 40, 1'b0, '0, 20, miso_w, r40);
        check("rst_frame_miso_tail", miso_w & 64'hF_FFFF, 64'd0);
        check("rst_frame_rx", {24'd0, rx_data_out}, 64'd0);
        check("rst_frame_valid", 64'(valid_cnt - v0), 64'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("rst_frame_err", 64'(err_cnt - e0), 64'd1);
`endif
        v0 = valid_cnt;
        spi_frame(40'h01_23_45_67_89, 40, 1'b0, '0, -1, miso_w, r40);
        check("post_rst_miso", miso_w, 64'd0);
        check("post_rst_rx", {24'd0, rx_data_out}, 64'h01_23_45_67_89);
        check("post_rst_valid", 64'(valid_cnt - v0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
